// File: rtl/nway_cache.sv
// N-way set-associative, write-back, write-allocate line cache.
// It uses tree pseudo-LRU replacement, fills invalid ways first, and merges byte-enabled writes.
module nway_cache #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int num_ways = 4,
    parameter int s_way    = $clog2(num_ways)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_byte_enable256,
    input  logic [255:0] mem_wdata256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int num_sets = 2 ** s_index;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    state_t              state_q, state_d;
    logic [s_tag-1:0]    req_tag_q, req_tag_d;
    logic [s_index-1:0]  req_idx_q, req_idx_d;
    logic                req_write_q, req_write_d;
    logic [31:0]         req_be_q, req_be_d;
    logic [255:0]        req_wdata_q, req_wdata_d;
    logic [s_way-1:0]    victim_q, victim_d;

    logic                valid_q [num_sets][num_ways];
    logic                valid_d [num_sets][num_ways];
    logic                dirty_q [num_sets][num_ways];
    logic                dirty_d [num_sets][num_ways];
    logic [num_ways-2:0] plru_q  [num_sets];
    logic [num_ways-2:0] plru_d  [num_sets];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [s_tag-1:0]    tag_d   [num_sets][num_ways];
    logic [255:0]        data_q  [num_sets][num_ways];
    logic [255:0]        data_d  [num_sets][num_ways];

    logic                hit;
    logic [s_way-1:0]    hit_way;
    logic [s_way-1:0]    victim_sel;
    logic [num_ways-2:0] plru_touched;
    logic                unused_offset;

    // The byte offset within the line never affects a line-granular access
    assign unused_offset = ^mem_address[s_offset-1:0];

    // Tag compare across all ways of the latched set
    always_comb begin
        logic [s_way-1:0] wi;
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            wi = s_way'(w);
            if (valid_q[req_idx_q][wi] && (tag_q[req_idx_q][wi] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = wi;
            end
        end
    end

    // Victim choice (lowest invalid way, else PLRU walk) and PLRU bits after touching the hit way
    always_comb begin
        logic [num_ways-2:0] bits;
        logic [s_way-1:0]    node;
        logic [s_way-1:0]    path;
        logic [s_way-1:0]    wi;
        logic                found;
        bits       = plru_q[req_idx_q];
        found      = 1'b0;
        victim_sel = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            wi = s_way'(w);
            if (!valid_q[req_idx_q][wi]) begin
                found      = 1'b1;
                victim_sel = wi;
            end
        end
        if (!found) begin
            node = '0;
            for (int l = 0; l < s_way; l++) begin
                victim_sel = (victim_sel << 1) | s_way'(bits[node]);
                node       = (node << 1) + s_way'(1) + s_way'(bits[node]);
            end
        end
        plru_touched = bits;
        node         = '0;
        path         = hit_way;
        for (int l = 0; l < s_way; l++) begin
            plru_touched[node] = ~path[s_way-1];
            node               = (node << 1) + s_way'(1) + s_way'(path[s_way-1]);
            path               = path << 1;
        end
    end

    // Control FSM: request latch, hit/miss handling, writeback and fill sequencing
    always_comb begin
        logic [255:0] line;
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_write_d  = req_write_q;
        req_be_d     = req_be_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        tag_d        = tag_q;
        data_d       = data_q;
        mem_rdata256 = '0;
        mem_resp     = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        line         = data_q[req_idx_q][hit_way];
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    req_tag_d   = mem_address[31 -: s_tag];
                    req_idx_d   = mem_address[s_offset +: s_index];
                    req_write_d = mem_write;
                    req_be_d    = mem_byte_enable256;
                    req_wdata_d = mem_wdata256;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    mem_resp          = 1'b1;
                    plru_d[req_idx_q] = plru_touched;
                    state_d           = IDLE;
                    if (req_write_q) begin
                        for (int b = 0; b < 32; b++) begin
                            if (req_be_q[b]) begin
                                line[b*8 +: 8] = req_wdata_q[b*8 +: 8];
                            end
                        end
                        data_d[req_idx_q][hit_way]  = line;
                        dirty_d[req_idx_q][hit_way] = 1'b1;
                    end else begin
                        mem_rdata256 = line;
                    end
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[req_idx_q][victim_sel] && dirty_q[req_idx_q][victim_sel]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[req_idx_q][victim_q], req_idx_q, {s_offset{1'b0}}};
                pmem_wdata   = data_q[req_idx_q][victim_q];
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag_q, req_idx_q, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    data_d[req_idx_q][victim_q]  = pmem_rdata;
                    tag_d[req_idx_q][victim_q]   = req_tag_q;
                    valid_d[req_idx_q][victim_q] = 1'b1;
                    dirty_d[req_idx_q][victim_q] = 1'b0;
                    state_d                      = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and per-line status bits; reset abandons any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_write_q <= 1'b0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            for (int s = 0; s < num_sets; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < num_ways; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_write_q <= req_write_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            plru_q      <= plru_d;
        end
    end

    // Tag and line storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: doc/nway_cache.md
Name: nway_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache: control FSM plus datapath in one block.
- Sits between the CPU-side 256-bit line interface (after the bus adapter) and physical memory.
- Generalises the fixed 2-way/8-set cache to any power-of-two way count.
- Uses a tree pseudo-LRU, fills invalid ways first, and merges writes per byte enable.

Parameters:
- s_offset, 5, line offset bits; line is 2**s_offset bytes, 256 bits at default.
- s_index, 3, set index bits; num_sets = 2**s_index.
- s_tag, 32-s_offset-s_index, tag bits (derived).
- num_ways, 4, associativity; power of two, >= 2.
- s_way, $clog2(num_ways), way-select width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- mem_address  in  32  CPU byte address.
- mem_read  in  1  CPU read request.
- mem_write  in  1  CPU write request.
- mem_byte_enable256  in  32  per-byte write enable.
- mem_wdata256  in  256  CPU write line.
- mem_rdata256  out  256  hit line to CPU.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned physical address.
- pmem_read  out  1  fill request.
- pmem_write  out  1  writeback request.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  physical memory done, one-cycle pulse.

Behaviour:
- Storage per set:
  - per way: valid, dirty, tag (s_tag), line (256).
  - per set: num_ways-1 PLRU bits.
- Reset (rst=0), asynchronous:
  - all valid, dirty and PLRU bits clear; state IDLE.
  - mem_resp, pmem_read, pmem_write, pmem_address, mem_rdata256, pmem_wdata all 0.
  - Reset mid-operation abandons the transaction immediately.
  - Line/tag contents after reset are don't-care.
- CPU handshake:
  - CPU holds mem_read/mem_write, address and data stable until mem_resp.
  - mem_read and mem_write together is illegal; the bench asserts it never occurs.
- FSM states and transitions:
  - IDLE: on mem_read|mem_write, latch request → CHECK.
  - CHECK: hit = valid & tag match in any way (at most one).
    - Hit, read: mem_rdata256 = hit line, mem_resp=1, PLRU update → IDLE.
    - Hit, write: merge bytes where enable=1, set dirty, mem_resp=1, PLRU update → IDLE.
    - Miss: select victim and register it → WRITEBACK if victim valid&dirty, else FILL.
  - WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line, all held steady. On pmem_resp → FILL.
  - FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp, write pmem_rdata into the victim way, set valid, clear dirty, load tag → CHECK, which then hits.
- Latency:
  - hit: mem_resp in the cycle after the request is first seen in IDLE (2 cycles request-to-resp).
  - miss: hit latency + fill wait (+ writeback wait) + 1.
- Victim selection:
  - lowest-index invalid way if any;
  - otherwise walk the PLRU tree from root node 0, children of node i at 2i+1 and 2i+2; bit 0 → go left (lower ways), 1 → go right.
- PLRU update on every hit (including the re-check after a fill): every node on the path to the accessed way points away from it (left half accessed → 1).
- pmem_read and pmem_write are never both 1. Neither asserts outside WRITEBACK/FILL. mem_resp is never high two consecutive cycles.
- Index/tag come from the latched address; a CPU address change mid-miss is illegal.

Test Plan:
- Cold read: reset, read 0x0000_0040 → pmem_read, pmem_address=0x40; pmem_resp with line 0xA5..A5 → mem_rdata256=0xA5..A5, mem_resp once. A repeat read gives mem_resp 2 cycles after the request, no pmem activity.
- Write hit: after the cold read, write 0x40, mem_byte_enable256=0x0000_000F, wdata=all 0x11 → read returns bytes 0-3 = 0x11, bytes 4-31 = 0xA5; no pmem traffic.
- PLRU: num_ways=4, read 0x000, 0x100, 0x200, 0x300, 0x000 (all index 0), then read 0x400 → victim way holding 0x200. No pmem_write (clean). Subsequent 0x100 hits, 0x200 misses.
- Dirty eviction: write 0x000, fill ways with 0x100/0x200/0x300, read 0x100, 0x200, 0x300, then read 0x400 → pmem_write with pmem_address=0x000 and the modified line first, then pmem_read at 0x400.
- Slow memory: pmem_resp delayed 10 cycles → pmem_read and pmem_address held constant throughout; mem_resp stays 0 until the fill completes.
- Reset mid-fill: drive rst=0 while pmem_read=1 → pmem_read and mem_resp 0 in the same cycle. After release, a read of the prior address misses (valid cleared).
